// File: rtl/booth_mul_ctrl_if.sv
// Avalon-MM slave bundle for booth_mul_ctrl.
// The irq wire exists only when BOOTH_MUL_CTRL_IRQ_EN is defined.
interface booth_mul_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busy;
    logic        done;
`ifdef BOOTH_MUL_CTRL_IRQ_EN
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, busy, done, irq
    );
    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, busy, done, irq
    );
`else
    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, busy, done
    );
    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, busy, done
    );
`endif
endinterface

// File: rtl/booth_mul_ctrl.sv
// Avalon-MM register file, control FSM and radix-2 Booth iterative signed multiplier.
// Optional interrupt support is enabled by defining BOOTH_MUL_CTRL_IRQ_EN.
module booth_mul_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    booth_mul_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic        [WIDTH-1:0]     opa_q, opa_d;
    logic        [WIDTH-1:0]     opb_q, opb_d;
    logic signed [WIDTH:0]       acc_q, acc_d;
    logic signed [WIDTH:0]       m_q, m_d;
    logic        [WIDTH-1:0]     q_q, q_d;
    logic                        q1_q, q1_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [2*WIDTH-1:0]   product_q, product_d;
    logic                        done_q, done_d;

    logic                        wr_en;
    logic                        go;
    logic                        clr_done;
    logic                        busy;
    logic                        irq;
    logic                        irq_en;
    logic signed [WIDTH:0]       sum;
    logic signed [63:0]          prod_ext;
    logic        [31:0]          rdata;
    logic                        unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign go           = wr_en && (bus.address == 3'd2) && bus.writedata[0];
    assign clr_done     = wr_en && (bus.address == 3'd2) && bus.writedata[1];
    assign busy         = (state_q != IDLE);
    assign unused_wdata = ^bus.writedata;

`ifdef BOOTH_MUL_CTRL_IRQ_EN
    logic irq_en_q, irq_en_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_en && (bus.address == 3'd2)) begin
            irq_en_d = bus.writedata[2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
        end
    end

    assign irq_en  = irq_en_q;
    assign irq     = done_q & irq_en_q;
    assign bus.irq = irq;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = done_q;
        sum       = acc_q;

        // Operand registers are frozen while an operation is in flight.
        if (wr_en && !busy) begin
            if (bus.address == 3'd0) opa_d = bus.writedata[WIDTH-1:0];
            if (bus.address == 3'd1) opb_d = bus.writedata[WIDTH-1:0];
        end

        // Clear first so that the DONE edge below wins a same-cycle collision.
        if (clr_done) done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) state_d = LOAD;
            end
            LOAD: begin
                acc_d   = '0;
                q_d     = opb_q;
                q1_d    = 1'b0;
                m_d     = (WIDTH+1)'(signed'(opa_q));
                cnt_d   = CNT_W'(WIDTH);
                state_d = ITER;
            end
            ITER: begin
                case ({q_q[0], q1_q})
                    2'b01:   sum = acc_q + m_q;
                    2'b10:   sum = acc_q - m_q;
                    default: sum = acc_q;
                endcase
                acc_d = sum >>> 1;
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                product_d = signed'({acc_q[WIDTH-1:0], q_q});
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Sign-extend the product to 64 bits so both result words slice cleanly for any WIDTH.
    assign prod_ext = 64'(product_q);

    always_comb begin
        rdata = 32'h0;
        case (bus.address)
            3'd0:    rdata = 32'(opa_q);
            3'd1:    rdata = 32'(opb_q);
            3'd2:    rdata = {29'b0, irq_en, 2'b0};
            3'd3:    rdata = {29'b0, irq, done_q, busy};
            3'd4:    rdata = prod_ext[31:0];
            3'd5:    rdata = prod_ext[63:32];
            default: rdata = 32'h0;
        endcase
    end

    assign bus.readdata = rdata;
    assign bus.busy     = busy;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed bench for booth_mul_ctrl: scoreboard of expected products, immediate-assertion checks.
module tb_booth_mul_ctrl;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    longint sb[$];

    booth_mul_ctrl_if bus ();

    booth_mul_ctrl #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [31:0] lo, hi;
        longint p;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            p = sb.pop_front();
            bus_read(3'd4, lo);
            bus_read(3'd5, hi);
            check({tag, "_res_lo"}, lo, p[31:0]);
            check({tag, "_res_hi"}, hi, p[63:32]);
        end
    endtask

    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] ctrl);
        int n;
        bus_write(3'd0, 32'(a));
        bus_write(3'd1, 32'(b));
        sb.push_back(longint'($signed(a)) * longint'($signed(b)));
        bus_write(3'd2, ctrl);
        check({tag, "_busy_after_go"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'd18);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check_result(tag);
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("rst_reg%0d", i), rd, 32'h0);
        end

        // Basic product with plain GO
        do_mul("basic", 16'd3, 16'd5, 32'h1);
        bus_read(3'd4, rd);
        check("basic_lo_const", rd, 32'h0000000F);
        bus_read(3'd3, rd);
        check("basic_status", rd, 32'h2);

        // GO together with CLR_DONE clears done and starts
        bus_write(3'd0, 32'h0000FFF9);
        bus_write(3'd1, 32'd6);
        sb.push_back(-64'sd42);
        bus_write(3'd2, 32'h3);
        check("goclr_done_cleared", 32'(bus.done), 32'd0);
        check("goclr_busy", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("signed_latency", 32'(n), 32'd18);
        check_result("signed");

        // Corner operands
        do_mul("min_min", 16'h8000, 16'h8000, 32'h3);
        bus_read(3'd4, rd);
        check("min_min_const", rd, 32'h40000000);
        do_mul("min_max", 16'h8000, 16'h7FFF, 32'h3);
        bus_read(3'd4, rd);
        check("min_max_const", rd, 32'hC0008000);
        do_mul("neg_neg", 16'hFFFF, 16'hFFFF, 32'h3);

        // CLR_DONE alone
        bus_write(3'd2, 32'h2);
        check("clr_done", 32'(bus.done), 32'd0);

        // Busy protection: writes and GO during a run are dropped
        bus_write(3'd0, 32'd2);
        bus_write(3'd1, 32'd3);
        sb.push_back(64'sd6);
        bus_write(3'd2, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        bus_write(3'd0, 32'd100);
        bus_write(3'd1, 32'd9);
        bus_write(3'd2, 32'h1);
        wait_done(n);
        check("busyprot_done", 32'(bus.done), 32'd1);
        check_result("busyprot");
        bus_read(3'd0, rd);
        check("busyprot_opa", rd, 32'd2);
        bus_read(3'd1, rd);
        check("busyprot_opb", rd, 32'd3);
        bus_write(3'd2, 32'h2);
        repeat (30) @(posedge clk);
        #1;
        check("busyprot_one_done", 32'(bus.done), 32'd0);
        check("busyprot_idle", 32'(bus.busy), 32'd0);

        // Writes to unmapped addresses are ignored
        bus_write(3'd6, 32'hDEADBEEF);
        bus_read(3'd6, rd);
        check("unmapped6", rd, 32'h0);
        bus_read(3'd0, rd);
        check("unmapped_opa", rd, 32'd2);

        // Reset abort mid-operation
        bus_write(3'd0, 32'd5);
        bus_write(3'd1, 32'd7);
        sb.push_back(64'sd35);
        bus_write(3'd2, 32'h1);
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        bus_read(3'd4, rd);
        check("abort_res_lo", rd, 32'h0);
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        do_mul("after_abort", 16'd4, 16'd4, 32'h1);
        bus_read(3'd4, rd);
        check("after_abort_const", rd, 32'd16);

`ifdef BOOTH_MUL_CTRL_IRQ_EN
        // Interrupt behaviour
        bus_write(3'd2, 32'h6);
        check("irq_idle", 32'(bus.irq), 32'd0);
        bus_read(3'd2, rd);
        check("irq_en_read", rd, 32'h4);
        do_mul("irq_mul", 16'd2, 16'd2, 32'h7);
        check("irq_rises", 32'(bus.irq), 32'd1);
        bus_read(3'd3, rd);
        check("irq_status", rd, 32'h6);
        bus_write(3'd2, 32'h6);
        check("irq_clr_done", 32'(bus.irq), 32'd0);
        do_mul("irq_mul2", 16'd2, 16'd2, 32'h7);
        bus_write(3'd2, 32'h0);
        check("irq_en_off", 32'(bus.irq), 32'd0);
        check("irq_en_off_done", 32'(bus.done), 32'd1);
`else
        // Without the interrupt feature, CTRL bit2 is inert
        bus_write(3'd2, 32'h4);
        bus_read(3'd2, rd);
        check("noirq_ctrl", rd, 32'h0);
        bus_read(3'd3, rd);
        check("noirq_status", rd, 32'h2);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
